// File: rtl/mem_cmp_pkg.sv
// Shared definitions for the memory compare checker: FSM state encoding and
// a saturating increment helper used by the result counters.
package mem_cmp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Widths up to 32 bits; callers cast to and from their own counter width.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
    return (val == max_val) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter
  import mem_cmp_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  localparam logic [CNT_W-1:0] MAX_CNT = '1;

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= CNT_W'(sat_inc(32'(r_count), 32'(MAX_CNT)));
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/mem_compare_checker.sv
// Streams generator vs. memory read-back words through a one-stage compare
// pipeline, counts compares/mismatches and captures the first failure.
// Optional per-bit compare mask enabled by defining CMP_MASK_EN.
//
// Handshake: a beat is accepted when cmp_valid=1 in RUN and start=0; its
// result appears exactly one cycle later as a one-cycle res_valid pulse.
// There is no backpressure.
module mem_compare_checker
  import mem_cmp_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              cmp_valid,
  input  logic [DATA_W-1:0] data_gen,
  input  logic [DATA_W-1:0] data_mem,
  input  logic [ADDR_W-1:0] addr,
`ifdef CMP_MASK_EN
  input  logic [DATA_W-1:0] data_mask,
`endif
  output logic              res_valid,
  output logic              is_equal,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic              err_flag,
  output logic [CNT_W-1:0]  err_count,
  output logic [CNT_W-1:0]  cmp_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_gen,
  output logic [DATA_W-1:0] first_err_mem,
  output logic [1:0]        dbg_state
);

  state_t r_state, w_next_state;

  logic              r_s1_valid;
  logic [DATA_W-1:0] r_s1_gen, r_s1_mem;
  logic [ADDR_W-1:0] r_s1_addr;
  logic [DATA_W-1:0] r_s1_mask;
  logic              r_err_flag;
  logic [ADDR_W-1:0] r_fe_addr;
  logic [DATA_W-1:0] r_fe_gen, r_fe_mem;

  logic w_accept, w_eq, w_count_en, w_mismatch;
  logic [DATA_W-1:0] w_mask;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  // start overrides everything, including a simultaneous stop.
  always_comb begin
    w_next_state = r_state;
    if (start) begin
      w_next_state = ST_RUN;
    end else begin
      case (r_state)
        ST_IDLE:  w_next_state = ST_IDLE;
        ST_RUN:   if (stop) w_next_state = ST_FLUSH;
        ST_FLUSH: w_next_state = ST_DONE;
        ST_DONE:  w_next_state = ST_DONE;
        default:  w_next_state = ST_IDLE;
      endcase
    end
  end

  assign w_accept = (r_state == ST_RUN) && cmp_valid && !start;

`ifdef CMP_MASK_EN
  assign w_mask = data_mask;
`else
  assign w_mask = '1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_gen   <= '0;
      r_s1_mem   <= '0;
      r_s1_addr  <= '0;
      r_s1_mask  <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_gen  <= data_gen;
        r_s1_mem  <= data_mem;
        r_s1_addr <= addr;
        r_s1_mask <= w_mask;
      end
    end
  end

  assign w_eq       = ~|((r_s1_gen ^ r_s1_mem) & r_s1_mask);
  // A result arriving in a start cycle belongs to the abandoned pass.
  assign w_count_en = r_s1_valid && !start;
  assign w_mismatch = w_count_en && !w_eq;

  // Capture keeps raw (unmasked) data so the failing word can be inspected.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_flag <= 1'b0;
      r_fe_addr  <= '0;
      r_fe_gen   <= '0;
      r_fe_mem   <= '0;
    end else if (start) begin
      r_err_flag <= 1'b0;
      r_fe_addr  <= '0;
      r_fe_gen   <= '0;
      r_fe_mem   <= '0;
    end else if (w_mismatch) begin
      r_err_flag <= 1'b1;
      if (!r_err_flag) begin
        r_fe_addr <= r_s1_addr;
        r_fe_gen  <= r_s1_gen;
        r_fe_mem  <= r_s1_mem;
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_clear (start),
    .i_inc   (w_mismatch),
    .o_count (err_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_cmp_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_clear (start),
    .i_inc   (w_count_en),
    .o_count (cmp_count)
  );

  assign res_valid      = r_s1_valid;
  assign is_equal       = r_s1_valid && w_eq;
  assign busy           = (r_state == ST_RUN) || (r_state == ST_FLUSH);
  assign done           = (r_state == ST_DONE);
  assign pass           = done && (err_count == '0);
  assign fail           = done && (err_count != '0);
  assign err_flag       = r_err_flag;
  assign first_err_addr = r_fe_addr;
  assign first_err_gen  = r_fe_gen;
  assign first_err_mem  = r_fe_mem;
  assign dbg_state      = r_state;

endmodule
